// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types, constants and the round-robin pick helper
package arb_pkg;
  localparam int N_REQ = 4;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = 4'b0001 << idx;
    end
  endfunction
endpackage

// File: rtl/rr_grant_arbiter_4_if.sv
// rr_grant_arbiter_4_if: request/grant bundle between requesters and the arbiter
interface rr_grant_arbiter_4_if;
  import arb_pkg::*;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] i_last;
  logic             i_ready;
  logic [N_REQ-1:0] o_grant;
  logic [1:0]       o_grant_idx;
  logic             o_busy;
  logic [N_REQ-1:0] o_ack;
  logic             o_timeout;
  modport master (output i_req, i_last, i_ready, input o_grant, o_grant_idx, o_busy, o_ack, o_timeout);
  modport slave  (input i_req, i_last, i_ready, output o_grant, o_grant_idx, o_busy, o_ack, o_timeout);
endinterface

// File: rtl/rr_priority_pick_4.sv
// rr_priority_pick_4: rotate requests by ptr, find first set, map back to a one-hot grant
module rr_priority_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [1:0]       o_idx,
  output logic             o_any
);
  logic [N_REQ-1:0] w_rot;
  logic [1:0]       w_off;
  for (genvar k = 0; k < N_REQ; k++) begin : g_rot
    assign w_rot[k] = i_req[i_ptr + 2'(k)];
  end
  assign w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_idx   = i_ptr + w_off;
  assign o_any   = |i_req;
  assign o_grant = o_any ? 4'b0001 << o_idx : '0;
endmodule

// File: rtl/rr_grant_arbiter_4.sv
// rr_grant_arbiter_4: round-robin arbiter holding a registered one-hot grant for multi-beat transfers
module rr_grant_arbiter_4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rr_grant_arbiter_4_if.slave  io_bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_LIM = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT_CYC);
  arb_state_t       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [1:0]       r_idx;
  logic [1:0]       r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_timeout;
  logic             w_busy, w_done, w_abort, w_to, w_rel, w_any;
  logic [1:0]       w_ptr, w_pidx;
  logic [N_REQ-1:0] w_pick;
  assign w_busy  = r_state == ARB_BUSY;
  assign w_done  = w_busy && io_bus.i_ready && io_bus.i_last[r_idx];
  assign w_abort = w_busy && !w_done && !io_bus.i_req[r_idx];
  assign w_to    = w_busy && !w_done && !w_abort && (r_cnt == C_LIM);
  assign w_rel   = w_done || w_abort || w_to;
  assign w_ptr   = w_rel ? r_idx + 2'd1 : r_ptr;
  rr_priority_pick_4 u_pick (
    .i_req   (io_bus.i_req),
    .i_ptr   (w_ptr),
    .o_grant (w_pick),
    .o_idx   (w_pidx),
    .o_any   (w_any)
  );
  // grant FSM: arbitrate when idle or on release (no bubble), otherwise hold and count
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to;
      r_ptr     <= w_ptr;
      if (!w_busy || w_rel) begin
        r_cnt   <= '0;
        r_grant <= w_pick;
        r_idx   <= w_any ? w_pidx : r_idx;
        r_state <= w_any ? ARB_BUSY : ARB_IDLE;
      end else begin
        r_cnt <= (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
      end
    end
  end
  assign io_bus.o_grant     = r_grant;
  assign io_bus.o_grant_idx = r_idx;
  assign io_bus.o_busy      = |r_grant;
  assign io_bus.o_ack       = r_grant & {N_REQ{io_bus.i_ready}};
  assign io_bus.o_timeout   = r_timeout;
endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// tb_rr_grant_arbiter_4: table-driven directed check of the round-robin grant arbiter
module tb_rr_grant_arbiter_4;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       to;
  } vec_t;
  vec_t tbl[$];
  rr_grant_arbiter_4_if bus ();
  rr_grant_arbiter_4 #(.TIMEOUT_CYC(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] l, logic y, logic [3:0] g, logic [3:0] a, logic t);
    vec_t v;
    v.rst = r; v.req = q; v.last = l; v.rdy = y; v.grant = g; v.ack = a; v.to = t;
    return v;
  endfunction
  function automatic logic [1:0] oh2i(logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    if (g == 4'b0010) r = 2'd1;
    if (g == 4'b0100) r = 2'd2;
    if (g == 4'b1000) r = 2'd3;
    return r;
  endfunction
  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask
  task automatic run_row(vec_t v, int n);
    rst = v.rst;
    bus.i_req = v.req;
    bus.i_last = v.last;
    bus.i_ready = v.rdy;
    #2;
    chk("grant", n, 32'(bus.o_grant), 32'(v.grant));
    chk("ack", n, 32'(bus.o_ack), 32'(v.ack));
    chk("busy", n, 32'(bus.o_busy), 32'(v.grant != 4'b0));
    chk("timeout", n, 32'(bus.o_timeout), 32'(v.to));
    chk("onehot", n, 32'($countones(bus.o_grant) <= 1), 32'(1));
    if (v.grant != 4'b0) chk("grant_idx", n, 32'(bus.o_grant_idx), 32'(oh2i(v.grant)));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    bus.i_req = 4'b0;
    bus.i_last = 4'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", -1, 32'(bus.o_grant), 32'(0));
    chk("rst_busy", -1, 32'(bus.o_busy), 32'(0));
    chk("rst_idx", -1, 32'(bus.o_grant_idx), 32'(0));
    chk("rst_timeout", -1, 32'(bus.o_timeout), 32'(0));
    chk("rst_ack", -1, 32'(bus.o_ack), 32'(0));
    repeat (5) tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0100, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b1000, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0010, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b1000, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 0));
    repeat (4) tbl.push_back(mk(1, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    repeat (7) tbl.push_back(mk(1, 4'b0010, 4'b1101, 1, 4'b0010, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0010, 1, 4'b0010, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0001, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    foreach (tbl[i]) run_row(tbl[i], i);
    run_row(mk(1, 4'b1001, 4'b0000, 1, 4'b0000, 4'b0000, 0), 100);
    for (int i = 1; i <= 8; i++) run_row(mk(1, 4'b1001, 4'b0000, 1, 4'b1000, 4'b1000, 0), 100 + i);
    run_row(mk(1, 4'b0000, 4'b0001, 1, 4'b0001, 4'b0001, 1), 109);
    run_row(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0), 110);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_grant_arbiter_4.md
Name: rr_grant_arbiter_4

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 one-hot special mux.
- Its registered one-hot grant drives the mux selection input, so the mux selection error flag can never fire.
- Grants are held for multi-beat transfers until the granted source flags its last beat, aborts, or times out.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 to match the mux width.
- TIMEOUT_CYC, 64, maximum cycles a grant may be held without release; range 2..1024.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-low.
- i_req  input  4  per-source request; a source holds it high for its whole transfer.
- i_last  input  4  per-source last-beat flag; only the granted bit is examined.
- i_ready  input  1  downstream accepts the current beat.
- o_grant  output  4  registered one-hot grant, or 0; drives the mux selection.
- o_grant_idx  output  2  encoded index of o_grant; valid only while o_busy=1.
- o_busy  output  1  a grant is active; equals OR of o_grant.
- o_ack  output  4  beat accepted per source: o_grant & {4{i_ready}}. Combinational.
- o_timeout  output  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (i_rst=0 at a rising edge):
  - o_grant=0, o_grant_idx=0, o_busy=0, o_timeout=0.
  - Priority pointer ptr=0 (source 0 highest), hold counter cnt=0.
  - Reset mid-transfer drops the grant at that edge; no ack, no timeout pulse.
- States: IDLE (o_grant=0) and BUSY (o_grant one-hot).
- Arbitration: pick the first i_req bit set, scanning ptr, ptr+1, ... modulo 4. A request is never skipped once ptr has passed other requesters.
- IDLE:
  - If i_req!=0, register the winner: o_grant is set at the next edge (1-cycle latency), state becomes BUSY, cnt=0.
  - Otherwise stay in IDLE.
- BUSY with granted index g:
  - o_grant is stable. cnt increments each cycle, saturating at TIMEOUT_CYC.
  - Release conditions, evaluated each cycle (priority order):
    - (a) i_ready & i_last[g]: normal completion. The beat is acked this cycle.
    - (b) !i_req[g]: abort. No ack is implied.
    - (c) cnt==TIMEOUT_CYC-1 with neither (a) nor (b): timeout. o_timeout=1 for the following cycle.
  - On any release:
    - ptr <= g+1 mod 4.
    - Re-arbitrate in the same cycle using ptr=g+1 and the current i_req. This gives back-to-back grants with no bubble.
    - If the re-arbitration finds requesters, load the new one-hot grant and reset cnt=0; else go to IDLE with o_grant=0.
    - Source g may be regranted only if it is the sole requester.
- Simultaneous (a) and (c) in the same cycle: treat as normal completion, no timeout pulse.
- i_last on non-granted sources: ignored.
- i_ready while IDLE: ignored; o_ack=0.
- Invariant: $countones(o_grant)<=1 in every cycle, including the cycle after reset.

Decomposition:
- Shared package arb_pkg:
  - N_REQ constant.
  - Enum arb_state_t {ARB_IDLE, ARB_BUSY}.
  - Function rr_pick(req[3:0], ptr[1:0]) returning a one-hot vector; reused by other arbiters in the design.
- One natural sub-module: rr_priority_pick_4, combinational rotate / find-first / unrotate.
- The FSM, pointer and counter stay in the top.
- The cnt width is $clog2(TIMEOUT_CYC+1).

Test Plan:
- Reset, then i_req=4'b0000 for 5 cycles -> o_grant=0, o_busy=0, o_ack=0 throughout.
- Single source:
  - Stimulus: i_req=4'b0100 at cycle 0; i_ready=1; i_last[2] high on the 3rd granted beat.
  - Response: o_grant=4'b0100 from cycle 1; o_ack[2] pulses 3 times; o_grant=0 at cycle 4; ptr=3.
- Fairness: all four requesting continuously, each transfer 1 beat (i_last=4'hF, i_ready=1) -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles, no bubbles.
- Backpressure: granted source 1 with i_last[1]=1 and i_ready=0 for 4 cycles, then i_ready=1 -> grant held 4 cycles, o_ack[1]=0 until i_ready=1, released the next cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; source 3 holds i_req, never asserts i_last; source 0 also requesting.
  - Response: o_timeout pulses once, 8 cycles after the grant; o_grant switches 1000->0001 in the same cycle.
- Abort and reset:
  - Granted source 2 drops i_req mid-transfer -> grant released next cycle without an o_timeout pulse.
  - Separately, i_rst=0 during BUSY -> o_grant=0 at that edge.
  - After reset, ptr=0: with all sources requesting, source 0 wins first.
